zeroriscy_mult_div_seq: RTL and testbench

ZERORISCY_MULT_DIV_SEQ -- requirements
Module: zeroriscy_mult_div_seq

---
 rtl/zeroriscy_defines.sv | 17 +
 rtl/zeroriscy_mult_div_seq.sv | 121 ++++++++++++
 tb/tb_zeroriscy_mult_div_seq.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/zeroriscy_defines.sv
// zeroriscy_defines: shared multiply/divide opcodes and sequencer state encoding.
package zeroriscy_defines;

    localparam logic [1:0] MD_OP_MULL = 2'b00;
    localparam logic [1:0] MD_OP_MULH = 2'b01;
    localparam logic [1:0] MD_OP_DIV  = 2'b10;
    localparam logic [1:0] MD_OP_REM  = 2'b11;

    typedef enum logic [2:0] {
        MD_IDLE,
        MD_ABS,
        MD_CALC,
        MD_FIX,
        MD_DONE
    } md_state_e;

endpackage

// File: rtl/zeroriscy_mult_div_seq.sv
// zeroriscy_mult_div_seq: 32-cycle sequential multiplier/divider sharing one 33-bit adder.
module zeroriscy_mult_div_seq
    import zeroriscy_defines::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        md_en_i,
    input  logic [1:0]  md_op_i,
    input  logic [1:0]  signed_mode_i,
    input  logic [31:0] op_a_i,
    input  logic [31:0] op_b_i,
    input  logic        kill_i,
    input  logic        ex_ready_i,
    output logic        ready_o,
    output logic        valid_o,
    output logic [31:0] result_o
);

    md_state_e   state, state_n;
    logic [1:0]  op_q, mode_q;
    logic [31:0] a_q, b_q, result_q, fix_sel;
    logic [63:0] acc;
    logic [5:0]  cnt;
    logic        sign_q, is_div, sa, sb, sub, div_zero;
    logic [32:0] b33, add_a, add_b, mul_new;
    logic        add_cin;
    logic [33:0] sum;

    assign is_div   = op_q[1];
    assign sa       = a_q[31] & mode_q[0] & (op_q != MD_OP_MULL);
    assign sb       = b_q[31] & mode_q[1] & (op_q != MD_OP_MULL);
    // B is never negated up front: a negative signed B flips add/subtract so CALC always uses |B|
    assign sub      = is_div ? ~sb : sb;
    assign b33      = {sb, b_q};
    assign div_zero = is_div && (b_q == '0);
    assign fix_sel  = op_q[0] ? acc[63:32] : acc[31:0];
    assign sum      = {1'b0, add_a} + {1'b0, add_b} + {33'b0, add_cin};
    assign mul_new  = acc[0] ? sum[32:0] : {1'b0, acc[63:32]};

    assign ready_o  = (state == MD_IDLE);
    assign valid_o  = (state == MD_DONE);
    assign result_o = result_q;

    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        case (state)
            MD_ABS: begin
                add_a   = {1'b0, ~a_q};
                add_cin = 1'b1;
            end
            MD_CALC: begin
                add_a   = is_div ? acc[63:31] : {1'b0, acc[63:32]};
                add_b   = sub ? ~b33 : b33;
                add_cin = sub;
            end
            MD_FIX: begin
                // MULH negates the full 64-bit product: carry into the high word only when low word is zero
                add_a   = {1'b0, ~fix_sel};
                add_cin = (op_q == MD_OP_MULH) ? (acc[31:0] == '0) : 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_n = state;
        case (state)
            MD_IDLE: state_n = (md_en_i && !kill_i) ? MD_ABS : MD_IDLE;
            MD_ABS:  state_n = div_zero ? MD_DONE : MD_CALC;
            MD_CALC: state_n = (cnt == 6'd31) ? MD_FIX : MD_CALC;
            MD_FIX:  state_n = MD_DONE;
            MD_DONE: state_n = ex_ready_i ? MD_IDLE : MD_DONE;
            default: state_n = MD_IDLE;
        endcase
        if (kill_i && state != MD_IDLE)
            state_n = MD_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= MD_IDLE;
            cnt      <= '0;
            acc      <= '0;
            result_q <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            mode_q   <= '0;
            sign_q   <= 1'b0;
        end else begin
            state <= state_n;
            case (state)
                MD_IDLE: if (md_en_i && !kill_i) begin
                    a_q    <= op_a_i;
                    b_q    <= op_b_i;
                    op_q   <= md_op_i;
                    mode_q <= signed_mode_i;
                    cnt    <= '0;
                end
                MD_ABS: begin
                    acc    <= {32'b0, sa ? sum[31:0] : a_q};
                    sign_q <= (op_q == MD_OP_REM) ? sa : (sa ^ sb);
                    cnt    <= '0;
                    if (div_zero)
                        result_q <= op_q[0] ? a_q : 32'hFFFF_FFFF;
                end
                MD_CALC: begin
                    // divide: carry-out of the trial subtraction is the quotient bit
                    acc <= is_div ? (sum[33] ? {sum[31:0], acc[30:0], 1'b1} : {acc[62:0], 1'b0})
                                  : {mul_new, acc[31:1]};
                    cnt <= cnt + 6'd1;
                end
                MD_FIX: result_q <= sign_q ? sum[31:0] : fix_sel;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_zeroriscy_mult_div_seq.sv
// tb_zeroriscy_mult_div_seq: directed vectors for the sequential multiplier/divider.
module tb_zeroriscy_mult_div_seq;
    import zeroriscy_defines::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        md_en_i = 1'b0;
    logic [1:0]  md_op_i = '0;
    logic [1:0]  signed_mode_i = '0;
    logic [31:0] op_a_i = '0;
    logic [31:0] op_b_i = '0;
    logic        kill_i = 1'b0;
    logic        ex_ready_i = 1'b1;
    logic        ready_o, valid_o;
    logic [31:0] result_o;
    int          checks = 0;
    int          errors = 0;

    zeroriscy_mult_div_seq dut (
        .clk(clk), .rst(rst), .md_en_i(md_en_i), .md_op_i(md_op_i),
        .signed_mode_i(signed_mode_i), .op_a_i(op_a_i), .op_b_i(op_b_i),
        .kill_i(kill_i), .ex_ready_i(ex_ready_i), .ready_o(ready_o),
        .valid_o(valid_o), .result_o(result_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // returns just after the accepting edge with garbage on the request inputs
    task automatic start_op(input logic [1:0] op, input logic [1:0] mode,
                            input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        md_en_i = 1'b1; md_op_i = op; signed_mode_i = mode; op_a_i = a; op_b_i = b;
        @(posedge clk);
        #1;
        md_en_i = 1'b0;
        md_op_i = 2'($urandom); signed_mode_i = 2'($urandom);
        op_a_i = $urandom; op_b_i = $urandom;
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [1:0] mode,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int exp_lat);
        int lat;
        start_op(op, mode, a, b);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!valid_o && lat < 60);
        check({tag, " lat"}, lat, exp_lat);
        check(tag, result_o, exp);
        @(negedge clk);
        check({tag, " rdy"}, {31'b0, ready_o}, 32'd1);
    endtask

    initial begin
        logic        saw;
        logic [31:0] held;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst ready", {31'b0, ready_o}, 32'd1);
        check("rst valid", {31'b0, valid_o}, 32'd0);
        check("rst result", result_o, 32'd0);
        rst = 1'b0;

        run_op("mull s", MD_OP_MULL, 2'b11, 32'h7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 35);
        run_op("mull u", MD_OP_MULL, 2'b00, 32'h7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 35);
        run_op("mulh 11", MD_OP_MULH, 2'b11, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 35);
        run_op("mulh 00", MD_OP_MULH, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 35);
        run_op("mulh 01", MD_OP_MULH, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 35);
        run_op("div s", MD_OP_DIV, 2'b11, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFD, 35);
        run_op("rem s", MD_OP_REM, 2'b11, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 35);
        run_op("div u", MD_OP_DIV, 2'b00, 32'hFFFF_FFF9, 32'h2, 32'h7FFF_FFFC, 35);
        run_op("rem u", MD_OP_REM, 2'b00, 32'd100, 32'd7, 32'd2, 35);
        run_op("div0", MD_OP_DIV, 2'b11, 32'd5, 32'd0, 32'hFFFF_FFFF, 2);
        run_op("rem0", MD_OP_REM, 2'b11, 32'd5, 32'd0, 32'd5, 2);
        run_op("div ovf", MD_OP_DIV, 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 35);
        run_op("rem ovf", MD_OP_REM, 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 35);

        // kill in flight at T+10
        start_op(MD_OP_MULL, 2'b00, 32'h1234, 32'h5678);
        saw = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            saw |= valid_o;
        end
        kill_i = 1'b1;
        @(negedge clk);
        kill_i = 1'b0;
        check("kill ready", {31'b0, ready_o}, 32'd1);
        check("kill valid", {31'b0, saw | valid_o}, 32'd0);
        run_op("after kill", MD_OP_MULL, 2'b00, 32'd3, 32'd4, 32'd12, 35);

        // reset in flight at T+20
        start_op(MD_OP_DIV, 2'b00, 32'd1000, 32'd3);
        saw = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            saw |= valid_o;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst2 ready", {31'b0, ready_o}, 32'd1);
        check("rst2 valid", {31'b0, saw | valid_o}, 32'd0);
        check("rst2 result", result_o, 32'd0);
        run_op("after rst", MD_OP_MULL, 2'b00, 32'd3, 32'd4, 32'd12, 35);

        // kill together with a request in IDLE must not start
        @(negedge clk);
        md_en_i = 1'b1; kill_i = 1'b1; md_op_i = MD_OP_DIV; op_a_i = 32'd9; op_b_i = 32'd0;
        @(negedge clk);
        md_en_i = 1'b0; kill_i = 1'b0;
        check("kill idle ready", {31'b0, ready_o}, 32'd1);
        repeat (2) @(negedge clk);
        check("kill idle valid", {31'b0, valid_o}, 32'd0);

        // consumer stall in DONE
        ex_ready_i = 1'b0;
        start_op(MD_OP_DIV, 2'b00, 32'd100, 32'd7);
        repeat (35) @(negedge clk);
        check("hold valid0", {31'b0, valid_o}, 32'd1);
        held = result_o;
        check("hold result0", held, 32'd14);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold valid", {31'b0, valid_o}, 32'd1);
            check("hold result", result_o, 32'd14);
            check("hold busy", {31'b0, ready_o}, 32'd0);
        end
        ex_ready_i = 1'b1;
        @(negedge clk);
        check("release ready", {31'b0, ready_o}, 32'd1);
        check("release valid", {31'b0, valid_o}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got hang expected finish");
        $fatal(1);
    end

endmodule
